// File: rtl/fb_pixel_writer.sv
// Pixel writer: buffers generator addresses in a FIFO and commits them to the framebuffer.
// Optional build macro FB_PIXEL_WRITER_CLIP_EN drops addresses outside the 640x480 frame.
module fb_pixel_writer #(
  parameter int FIFO_DEPTH  = 8,
  parameter int STOP_THRESH = 6,
  parameter int COLOR_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               primSelect,
  input  logic [COLOR_W-1:0] color,
  input  logic [18:0]        address,
  input  logic               lineDone,
  output logic               stop,
  output logic [18:0]        mem_addr,
  output logic [COLOR_W-1:0] mem_wdata,
  output logic               mem_we,
  input  logic               mem_ready,
  output logic               busy,
  output logic               write_done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} state_t;

  state_t             state;
  logic [18:0]        fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [COLOR_W-1:0] color_q;
  logic [18:0]        last_addr;
  logic               last_valid;
  logic               accept;
  logic               in_range;
  logic               dup;
  logic               push;
  logic               pop;

  always_comb begin
`ifdef FB_PIXEL_WRITER_CLIP_EN
    in_range = (address < 19'd307200);
`else
    in_range = 1'b1;
`endif
    stop       = (state == CAPTURE) && (count >= CNT_W'(STOP_THRESH));
    mem_we     = ((state == CAPTURE) || (state == DRAIN)) && (count != '0);
    accept     = (state == CAPTURE) && !stop;
    dup        = last_valid && (address == last_addr);
    push       = accept && in_range && !dup;
    pop        = mem_we && mem_ready;
    // Address is forced to zero when idle so stale FIFO contents never show.
    mem_addr   = mem_we ? fifo[rd_ptr] : '0;
    mem_wdata  = color_q;
    busy       = (state != IDLE);
    write_done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= address;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      color_q    <= '0;
      last_addr  <= '0;
      last_valid <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + 1'b1;
        last_addr  <= address;
        last_valid <= 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      case (state)
        IDLE: begin
          if (primSelect) begin
            state      <= CAPTURE;
            color_q    <= color;
            last_valid <= 1'b0;
          end
        end
        CAPTURE: begin
          if (accept && lineDone) state <= DRAIN;
        end
        DRAIN: begin
          // Nothing is pushed here, so the FIFO empties exactly when the last entry pops.
          if ((count == '0) || ((count == CNT_W'(1)) && pop)) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Scoreboard bench for fb_pixel_writer: directed lines, expected writes queued, monitor compares.
module tb_fb_pixel_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        primSelect = 1'b0;
  logic [7:0]  color = '0;
  logic [18:0] address = '0;
  logic        lineDone = 1'b0;
  logic        stop;
  logic [18:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_ready = 1'b1;
  logic        busy;
  logic        write_done;

  fb_pixel_writer #(.FIFO_DEPTH(8), .STOP_THRESH(6), .COLOR_W(8)) dut (
    .clk(clk), .rst(rst), .primSelect(primSelect), .color(color),
    .address(address), .lineDone(lineDone), .stop(stop),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_ready(mem_ready), .busy(busy), .write_done(write_done)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [26:0] exp_q[$];
  logic [18:0] stim[$];
  int          ps_at = -1;
  int          acc = 0;
  int          pops = 0;
  int          max_occ = 0;
  int          done_cnt = 0;
  int          done_exp = 0;
  bit          stop_seen = 1'b0;
  bit          prev_stall = 1'b0;
  logic [18:0] held_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every completed write against the scoreboard.
  always @(negedge clk) begin
    if ((acc - pops) > max_occ) max_occ = acc - pops;
    if (stop) stop_seen = 1'b1;
    if (write_done) done_cnt++;
    if (prev_stall && mem_we && !rst) chk("hold_addr", {13'd0, mem_addr}, {13'd0, held_addr});
    if (mem_we && mem_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d with no write expected", mem_addr);
      end else begin
        logic [26:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", {13'd0, mem_addr}, {13'd0, e[26:8]});
        chk("wr_data", {24'd0, mem_wdata}, {24'd0, e[7:0]});
      end
    end
    prev_stall = mem_we && !mem_ready && !rst;
    held_addr  = mem_addr;
  end

  task automatic add_exp(input logic [18:0] a, input logic [7:0] c);
    exp_q.push_back({a, c});
  endtask

  task automatic start_line(input logic [7:0] c);
    @(posedge clk); #2;
    primSelect = 1'b1;
    color = c;
    @(posedge clk); #2;
    primSelect = 1'b0;
  endtask

  // Presents each stim address until accepted (stop low at the edge).
  task automatic run_stim(input bit last);
    for (int i = 0; i < stim.size(); i++) begin
      int guard = 0;
      address    = stim[i];
      lineDone   = last && (i == stim.size() - 1);
      primSelect = (i == ps_at);
      while (stop && guard < 200) begin
        @(posedge clk); #2;
        guard++;
      end
      if (guard >= 200) chk("accept_timeout", 32'(guard), 32'd0);
      @(posedge clk); #2;
      acc++;
      primSelect = 1'b0;
    end
    lineDone = 1'b0;
  endtask

  task automatic wait_done();
    int g = 0;
    done_exp++;
    while (done_cnt < done_exp && g < 300) begin
      @(posedge clk); #2;
      g++;
    end
    repeat (3) @(posedge clk);
    #2;
    chk("write_done_count", 32'(done_cnt), 32'(done_exp));
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("rst_stop", {31'd0, stop}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {13'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_write_done", {31'd0, write_done}, 32'd0);
    rst = 1'b0;

    // Basic three-pixel line
    stop_seen = 1'b0;
    for (int a = 100; a <= 102; a++) add_exp(19'(a), 8'hA5);
    start_line(8'hA5);
    chk("busy_capture", {31'd0, busy}, 32'd1);
    stim = '{19'd100, 19'd101, 19'd102};
    run_stim(1'b1);
    wait_done();
    chk("no_stop_full_rate", {31'd0, stop_seen}, 32'd0);

    // Duplicate suppression
    add_exp(19'd5, 8'h3C); add_exp(19'd6, 8'h3C); add_exp(19'd7, 8'h3C);
    start_line(8'h3C);
    stim = '{19'd5, 19'd5, 19'd5, 19'd6, 19'd6, 19'd7};
    run_stim(1'b1);
    wait_done();

    // Backpressure: memory stalled for 20 cycles during a 10-pixel line
    acc = 0; pops = 0; max_occ = 0; stop_seen = 1'b0;
    mem_ready = 1'b0;
    for (int a = 200; a <= 209; a++) add_exp(19'(a), 8'h5A);
    start_line(8'h5A);
    stim = '{19'd200, 19'd201, 19'd202, 19'd203, 19'd204,
             19'd205, 19'd206, 19'd207, 19'd208, 19'd209};
    fork
      run_stim(1'b1);
      begin
        repeat (20) @(posedge clk);
        #1;
        chk("accepts_while_stalled", 32'(acc), 32'd6);
        chk("stop_while_stalled", {31'd0, stop}, 32'd1);
        mem_ready = 1'b1;
      end
    join
    wait_done();
    chk("stop_seen", {31'd0, stop_seen}, 32'd1);
    chk("max_occupancy", 32'(max_occ), 32'd6);

    // Reset mid-line with 4 queued entries
    mem_ready = 1'b0;
    start_line(8'h11);
    stim = '{19'd300, 19'd301, 19'd302, 19'd303};
    run_stim(1'b0);
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    chk("midrst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_stop", {31'd0, stop}, 32'd0);
    chk("midrst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    mem_ready = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    chk("midrst_no_done", 32'(done_cnt), 32'(done_exp));
    add_exp(19'd310, 8'h77); add_exp(19'd311, 8'h77);
    start_line(8'h77);
    stim = '{19'd310, 19'd311};
    run_stim(1'b1);
    wait_done();

    // Out-of-frame addresses
    add_exp(19'd307199, 8'hC3);
`ifndef FB_PIXEL_WRITER_CLIP_EN
    add_exp(19'd307200, 8'hC3);
    add_exp(19'd400000, 8'hC3);
`endif
    start_line(8'hC3);
    stim = '{19'd307199, 19'd307200, 19'd400000};
    run_stim(1'b1);
    wait_done();

    // lineDone while idle, primSelect while capturing
    lineDone = 1'b1;
    address  = 19'd999;
    repeat (2) @(posedge clk);
    #2;
    lineDone = 1'b0;
    chk("idle_linedone_busy", {31'd0, busy}, 32'd0);
    chk("idle_linedone_we", {31'd0, mem_we}, 32'd0);
    for (int a = 400; a <= 402; a++) add_exp(19'(a), 8'h96);
    start_line(8'h96);
    color = 8'h33;
    ps_at = 1;
    stim = '{19'd400, 19'd401, 19'd402};
    run_stim(1'b1);
    ps_at = -1;
    wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_pixel_writer.md
# fb_pixel_writer

Consumer end of the line generator's address stream: captures the per-cycle 19-bit pixel addresses produced while a line primitive is being drawn, buffers them in a small FIFO, and writes each pixel into framebuffer memory through a ready/valid write port. It throttles the generator with `stop` when its FIFO fills and reports completion once every captured pixel has been committed to memory. Sits between `bresenline` and the framebuffer SRAM controller.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: address FIFO entries (power of two, ≥4)
- `STOP_THRESH`, 6: FIFO occupancy at which `stop` asserts (2 ≤ STOP_THRESH ≤ FIFO_DEPTH)
- `COLOR_W`, 8: pixel data width

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `primSelect`  in  1  line start request from the primitive decoder
- `color`  in  COLOR_W  pixel value, sampled when a line starts
- `address`  in  19  pixel address from the generator, `{y*640+x}`
- `lineDone`  in  1  generator's last-pixel indicator
- `stop`  out  1  pause request to the generator
- `mem_addr`  out  19  framebuffer write address
- `mem_wdata`  out  COLOR_W  framebuffer write data
- `mem_we`  out  1  write valid
- `mem_ready`  in  1  memory accepts write when `mem_we & mem_ready`
- `busy`  out  1  high in any state but IDLE
- `write_done`  out  1  one-cycle pulse when the line is fully written

## Operation
- FSM states: IDLE, CAPTURE, DRAIN, DONE.
- IDLE: `primSelect`=1 → CAPTURE; latch `color`; clear last-address-valid flag; FIFO is already empty.
- CAPTURE: an input cycle is *accepted* when `stop`=0. On accept, `address` is pushed unless it equals the last pushed address (duplicate suppression; generator holds address when stalled or finished). Accept with `lineDone`=1 pushes that final address (subject to the same rules) and → DRAIN.
- DRAIN: no capture; → DONE when FIFO empty and no write outstanding.
- DONE: `write_done`=1 for exactly one cycle → IDLE.
- `primSelect` outside IDLE is ignored; `lineDone` outside CAPTURE is ignored.
- `stop` = (state==CAPTURE) & (count ≥ STOP_THRESH), combinational from registered count only.
- Write port: `mem_we` = FIFO non-empty (CAPTURE or DRAIN); `mem_addr` = FIFO head, `mem_wdata` = latched color. Pop on `mem_we & mem_ready`. `mem_addr`/`mem_wdata` stable while `mem_we` high and `mem_ready` low.
- Simultaneous push and pop: count unchanged, both take effect. Push never occurs when full (guaranteed by STOP_THRESH ≤ FIFO_DEPTH).
- FIFO pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.

## Timing
- Reset (any state, mid-line included): state IDLE, FIFO flushed, `stop`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `write_done`=0. Pending memory writes are discarded.
- `primSelect` at edge N → CAPTURE at N+1; first address accept possible in cycle N+1.
- Address accepted at edge K with empty FIFO → `mem_we`=1 from cycle K+1.
- Throughput: one pixel/cycle with `mem_ready` held high; `stop` never asserts then.
- `write_done` asserts the cycle after the final pop completes (DRAIN → DONE one edge).

## Configuration
- `FB_PIXEL_WRITER_CLIP_EN`: when defined, accepted addresses ≥ 307200 (outside 640×480) are not pushed and do not update the last-address register; `lineDone` still ends capture. When undefined, every non-duplicate address is pushed regardless of value.

## Test plan
- Reset then `primSelect` with `color`=8'hA5, addresses 100,101,102 (`lineDone` on 102), `mem_ready`=1 → three writes addr 100/101/102 data A5, `write_done` pulse, `stop` never high.
- Address stream 5,5,5,6,6,7(lineDone) → exactly writes 5,6,7.
- `mem_ready`=0 for 20 cycles during a 10-pixel line → `stop` rises when count reaches 6, no further accepts, FIFO never exceeds 6; after release all 10 written in order.
- `rst` asserted mid-line with 4 entries queued → next cycle `mem_we`=0, `busy`=0, no `write_done`; a new line then writes only its own pixels.
- With `FB_PIXEL_WRITER_CLIP_EN`: stream 307199, 307200, 400000(lineDone) → single write to 307199, then `write_done`; without macro → three writes.
- `primSelect` pulsed during CAPTURE and `lineDone` in IDLE → no state change, no extra writes.
